// File: rtl/operand_normalizer_pkg.sv
// Shared definitions for the normalizer / shifter / multiplier slice:
// default operand and mantissa widths, the shift-amount width derivation,
// and the packed result record passed between the datapath blocks.
package norm_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_K     = 4;

    // Width needed to hold a bit index of a WIDTH-bit operand.
    function automatic int unsigned shw_of(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned DEF_SHW = shw_of(DEF_WIDTH);

    typedef struct packed {
        logic [DEF_K-1:0]   mant;
        logic [DEF_SHW-1:0] shift;
        logic               zero;
    } norm_result_t;

endpackage

// File: rtl/operand_normalizer_if.sv
// Operand-in / result-out handshake bundle for operand_normalizer.
// slave  : the normalizer side (accepts operands, produces results).
// master : the producer/consumer side that drives operands and out_ready.
interface operand_normalizer_if #(
    parameter int unsigned WIDTH = norm_pkg::DEF_WIDTH,
    parameter int unsigned K     = norm_pkg::DEF_K,
    parameter int unsigned SHW   = norm_pkg::shw_of(WIDTH)
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    logic             out_valid;
    logic             out_ready;
    logic [K-1:0]     out_mant;
    logic [SHW-1:0]   out_shift;
    logic             out_zero;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_mant,
        input  out_shift,
        input  out_zero
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_mant,
        output out_shift,
        output out_zero
    );

endinterface

// File: rtl/operand_normalizer_lod.sv
// Combinational leading-one detector: index of the most significant set bit
// of data, plus a flag for an all-zero operand (index reads 0 in that case).
module lod_priority #(
    parameter int unsigned WIDTH = norm_pkg::DEF_WIDTH,
    parameter int unsigned SHW   = norm_pkg::shw_of(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   lead,
    output logic             zero
);

    // Scan upward so the highest set bit is the last one to claim lead.
    always_comb begin
        lead = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                lead = SHW'(i);
            end
        end
        zero = ~|data;
    end

endmodule

// File: rtl/operand_normalizer.sv
// Two-stage leading-one normalizer. Stage 1 registers the operand with its
// leading-one index; stage 2 truncates to a K-bit mantissa aligned at that
// leading one, forces the LSB when bits were dropped, and reports the right
// shift so a downstream shifter can restore the magnitude.
module operand_normalizer
    import norm_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned K     = DEF_K
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_normalizer_if.slave  bus
);

    localparam int unsigned SHW = shw_of(WIDTH);

    // Whole pipeline advances together; a stalled output freezes stage 1 too.
    logic             en;

    logic [SHW-1:0]   lod_lead;
    logic             lod_zero;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [SHW-1:0]   s1_lead;
    logic             s1_zero;

    logic [K-1:0]     s2_mant;
    logic [SHW-1:0]   s2_shift;

    logic             out_valid_q;
    logic [K-1:0]     out_mant_q;
    logic [SHW-1:0]   out_shift_q;
    logic             out_zero_q;

    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

    assign bus.out_valid = out_valid_q;
    assign bus.out_mant  = out_mant_q;
    assign bus.out_shift = out_shift_q;
    assign bus.out_zero  = out_zero_q;

    lod_priority #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_lod (
        .data (bus.in_data),
        .lead (lod_lead),
        .zero (lod_zero)
    );

    // Stage 1: capture operand, leading-one index and zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_lead  <= '0;
            s1_zero  <= 1'b0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_data  <= bus.in_data;
            s1_lead  <= lod_lead;
            s1_zero  <= lod_zero;
        end
    end

    // Stage 2 datapath: shift amount, mantissa window and LSB forcing.
    always_comb begin
        s2_shift = '0;
        s2_mant  = s1_data[K-1:0];
        if (int'(s1_lead) > int'(K) - 1) begin
            s2_shift   = s1_lead - SHW'(K - 1);
            s2_mant    = K'(s1_data >> s2_shift);
            s2_mant[0] = 1'b1;
        end
    end

    // Stage 2: output registers, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_shift_q <= '0;
            out_zero_q  <= 1'b0;
        end else if (en) begin
            out_valid_q <= s1_valid;
            out_mant_q  <= s2_mant;
            out_shift_q <= s2_shift;
            out_zero_q  <= s1_zero;
        end
    end

endmodule

// File: tb/tb_operand_normalizer.sv
// Bench for operand_normalizer (WIDTH=8, K=4): directed vectors with literal
// expectations plus a scoreboard that checks every delivered result against
// an arithmetic reference of the normalization rules.
module tb_operand_normalizer;
    import norm_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned K     = 4;
    localparam int          KI    = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_normalizer_if #(.WIDTH(WIDTH), .K(K)) bus ();

    operand_normalizer #(.WIDTH(WIDTH), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: find the leading one arithmetically, keep K bits from it.
    function automatic void model(input int x, output int m, output int s, output int z);
        int p;
        m = 0;
        s = 0;
        z = (x == 0) ? 1 : 0;
        if (x != 0) begin
            p = 0;
            while ((x >> (p + 1)) != 0) p++;
            if (p <= KI - 1) begin
                m = x;
            end else begin
                s = p - (KI - 1);
                m = (x >> s) | 1;
            end
        end
    endfunction

    // Scoreboard / compare process, sampled on the falling edge.
    logic       prev_hold = 1'b0;
    logic [3:0] prev_m;
    logic [2:0] prev_s;
    logic       prev_z;
    always @(negedge clk) begin
        int x, m, s, z;
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_mant", bus.out_mant, prev_m);
                check("hold_shift", bus.out_shift, prev_s);
                check("hold_zero", bus.out_zero, prev_z);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got mant 0x%0h with no operand outstanding at %0t",
                             bus.out_mant, $time);
                end else begin
                    x = int'(exp_q.pop_front());
                    model(x, m, s, z);
                    check($sformatf("mant[0x%0h]", x), bus.out_mant, m);
                    check($sformatf("shift[0x%0h]", x), bus.out_shift, s);
                    check($sformatf("zero[0x%0h]", x), bus.out_zero, z);
                    check($sformatf("restore_ge[0x%0h]", x),
                          ((int'(bus.out_mant) << bus.out_shift) >= ((x >> bus.out_shift) << bus.out_shift)) ? 1 : 0,
                          1);
                    n_out++;
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_m    = bus.out_mant;
            prev_s    = bus.out_shift;
            prev_z    = bus.out_zero;
            if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
        end
    end

    // One operand into an idle pipeline with literal expected results.
    task automatic send_single(input logic [7:0] d, input logic [3:0] em, input logic [2:0] es, input logic ez);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        check($sformatf("idle_in_ready[0x%0h]", d), bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check($sformatf("lat_not_yet[0x%0h]", d), bus.out_valid, 0);
        @(posedge clk);
        #1;
        check($sformatf("lat_valid[0x%0h]", d), bus.out_valid, 1);
        check($sformatf("lit_mant[0x%0h]", d), bus.out_mant, em);
        check($sformatf("lit_shift[0x%0h]", d), bus.out_shift, es);
        check($sformatf("lit_zero[0x%0h]", d), bus.out_zero, ez);
    endtask

    // Present one operand and return just after the edge that accepts it.
    task automatic push(input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) check($sformatf("push_timeout[0x%0h]", d), 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", (n < 300) ? 1 : 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        logic [7:0] vals[256];
        logic done;

        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_mant", bus.out_mant, 0);
        check("rst_shift", bus.out_shift, 0);
        check("rst_zero", bus.out_zero, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send_single(8'hB6, 4'hB, 3'd4, 1'b0);
        send_single(8'h30, 4'hD, 3'd2, 1'b0);
        send_single(8'h24, 4'h9, 3'd2, 1'b0);
        send_single(8'h08, 4'h8, 3'd0, 1'b0);
        send_single(8'h05, 4'h5, 3'd0, 1'b0);
        send_single(8'h00, 4'h0, 3'd0, 1'b1);
        send_single(8'hFF, 4'hF, 3'd4, 1'b0);
        drain();

        // Back-to-back stream with a three-cycle consumer stall mid-stream.
        start = n_out;
        fork
            begin
                for (int v = 1; v <= 16; v++) push(8'(v));
            end
            begin
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", bus.in_ready, 0);
                    check("stall_out_valid", bus.out_valid, 1);
                    @(posedge clk);
                end
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", n_out - start, 16);

        // Reset with both stages occupied.
        push(8'hA1);
        push(8'hC3);
        check("pre_rst_out_valid", bus.out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_mant", bus.out_mant, 0);
        check("mid_rst_shift", bus.out_shift, 0);
        check("mid_rst_zero", bus.out_zero, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_no_stale", bus.out_valid, 0);
        end

        // Every operand value, shuffled, with random gaps and random out_ready.
        for (int i = 0; i < 256; i++) vals[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int j;
            logic [7:0] t;
            j = int'($urandom_range(i, 0));
            t = vals[i];
            vals[i] = vals[j];
            vals[j] = t;
        end
        start = n_out;
        done  = 1'b0;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    repeat ($urandom_range(1, 0)) begin
                        @(posedge clk);
                        #1;
                    end
                    push(vals[i]);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(3, 0) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        check("sweep_count", n_out - start, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
